// File: rtl/id_decode_stage.sv
// id_decode_stage: instruction-decode stage between fetch and execute.
//
// Decodes a 32-bit RISC-V instruction (R/I/S/B/U/J) into control fields, register ids and
// an XLEN sign-extended immediate, and holds decoded entries in an elastic valid/ready
// buffer of BUF_DEPTH (1 or 2) entries with flush.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   flush                     drop all buffered entries and this cycle's input
//   in_valid/in_ready         fetch handshake; in_instr, in_pc carry the instruction
//   out_valid/out_ready       execute handshake; out_* is the head entry (all 0 when empty)
//   occupancy                 number of entries held
//
// Optional feature: define ILLEGAL_INSTR_FLAG_EN to add out_illegal, which marks entries
// that decoded as a bubble (unknown opcode or reserved branch funct3).
//
// Encodings:
//   alu_op:   0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND,
//             10 B_BEQ, 11 B_BNE, 12 B_BLT, 13 B_BGE, 14 B_LTU, 15 B_GEU
//   encoding: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J
// Register ids are always the raw instruction fields rs1=[19:15], rs2=[24:20], rd=[11:7].

module id_decode_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned REG_ADDR_W = 6,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_W-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic [3:0]            out_alu_op,
  output logic [2:0]            out_encoding,
  output logic                  out_alu_src,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic                  out_is_branch,
  output logic                  out_is_jump,
`ifdef ILLEGAL_INSTR_FLAG_EN
  output logic                  out_illegal,
`endif
  output logic [1:0]            occupancy
);

  if (!(BUF_DEPTH == 1 || BUF_DEPTH == 2)) begin : g_bad_depth
    $error("id_decode_stage: BUF_DEPTH must be 1 or 2");
  end

  // ALU operation codes
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;
  localparam logic [3:0] BBeq    = 4'd10;
  localparam logic [3:0] BBne    = 4'd11;
  localparam logic [3:0] BBlt    = 4'd12;
  localparam logic [3:0] BBge    = 4'd13;
  localparam logic [3:0] BLtu    = 4'd14;
  localparam logic [3:0] BGeu    = 4'd15;

  // Encoding types
  localparam logic [2:0] EncR = 3'd0;
  localparam logic [2:0] EncI = 3'd1;
  localparam logic [2:0] EncS = 3'd2;
  localparam logic [2:0] EncB = 3'd3;
  localparam logic [2:0] EncU = 3'd4;
  localparam logic [2:0] EncJ = 3'd5;

  // Major opcodes
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic [3:0]            alu_op;
    logic [2:0]            encoding;
    logic                  alu_src;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  is_branch;
    logic                  is_jump;
`ifdef ILLEGAL_INSTR_FLAG_EN
    logic                  illegal;
`endif
  } entry_t;

  // ---------------------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  alu_by_f3;
  logic [3:0]  br_by_f3;
  logic        br_reserved;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7_5 = in_instr[30];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    alu_by_f3 = AluAdd;
    case (funct3)
      3'b000:  alu_by_f3 = AluAdd;
      3'b001:  alu_by_f3 = AluSll;
      3'b010:  alu_by_f3 = AluSlt;
      3'b011:  alu_by_f3 = AluSltu;
      3'b100:  alu_by_f3 = AluXor;
      3'b101:  alu_by_f3 = AluSrl;
      3'b110:  alu_by_f3 = AluOr;
      default: alu_by_f3 = AluAnd;
    endcase
  end

  always_comb begin
    br_by_f3    = BBeq;
    br_reserved = 1'b0;
    case (funct3)
      3'b000:  br_by_f3 = BBeq;
      3'b001:  br_by_f3 = BBne;
      3'b100:  br_by_f3 = BBlt;
      3'b101:  br_by_f3 = BBge;
      3'b110:  br_by_f3 = BLtu;
      3'b111:  br_by_f3 = BGeu;
      default: br_reserved = 1'b1;
    endcase
  end

  entry_t             dec;
  logic signed [31:0] imm32;
  logic               illegal;

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.rs1      = REG_ADDR_W'(in_instr[19:15]);
    dec.rs2      = REG_ADDR_W'(in_instr[24:20]);
    dec.rd       = REG_ADDR_W'(in_instr[11:7]);
    dec.alu_op   = AluAdd;
    dec.encoding = EncI;
    imm32        = '0;
    illegal      = 1'b0;

    case (opcode)
      OpReg: begin
        dec.encoding  = EncR;
        dec.alu_op    = alu_by_f3;
        if (funct7_5 && funct3 == 3'b000) dec.alu_op = AluSub;
        if (funct7_5 && funct3 == 3'b101) dec.alu_op = AluSra;
        dec.reg_write = 1'b1;
      end
      OpImm: begin
        dec.alu_op    = alu_by_f3;
        // funct7[5] is part of the immediate except for the right shifts
        if (funct7_5 && funct3 == 3'b101) dec.alu_op = AluSra;
        imm32         = imm_i;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OpLoad: begin
        imm32          = imm_i;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OpStore: begin
        dec.encoding  = EncS;
        imm32         = imm_s;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OpBranch: begin
        dec.encoding  = EncB;
        dec.alu_op    = br_by_f3;
        imm32         = imm_b;
        dec.is_branch = 1'b1;
        illegal       = br_reserved;
      end
      OpJal: begin
        dec.encoding  = EncJ;
        imm32         = imm_j;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.is_jump   = 1'b1;
      end
      OpJalr: begin
        imm32         = imm_i;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.is_jump   = 1'b1;
      end
      OpLui, OpAuipc: begin
        dec.encoding  = EncU;
        imm32         = imm_u;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      // Bubble: keeps the slot but does nothing downstream
      dec.encoding   = EncI;
      dec.alu_op     = AluAdd;
      dec.alu_src    = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.reg_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.is_branch  = 1'b0;
      dec.is_jump    = 1'b0;
      imm32          = '0;
    end

    dec.imm = XLEN'(imm32);  // signed source, so this sign-extends
`ifdef ILLEGAL_INSTR_FLAG_EN
    dec.illegal = illegal;
`endif
  end

  // ---------------------------------------------------------------------------------------
  // Elastic buffer
  // ---------------------------------------------------------------------------------------
  // Two slots are always declared; with BUF_DEPTH == 1 the pointers never leave slot 0.
  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;
  entry_t     head;

  function automatic logic ptr_next(input logic p);
    return (BUF_DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  always_comb begin
    if (!reset_n || flush) begin
      in_ready = 1'b0;
    end else if (BUF_DEPTH == 1) begin
      in_ready = (count_q == 2'd0) || out_ready;
    end else begin
      in_ready = (count_q < 2'd2);
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A pop this cycle still completes on the output side; nothing survives.
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is forced to zero whenever the buffer is empty
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc         = head.pc;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_rd         = head.rd;
  assign out_imm        = head.imm;
  assign out_alu_op     = head.alu_op;
  assign out_encoding   = head.encoding;
  assign out_alu_src    = head.alu_src;
  assign out_mem_read   = head.mem_read;
  assign out_mem_write  = head.mem_write;
  assign out_reg_write  = head.reg_write;
  assign out_mem_to_reg = head.mem_to_reg;
  assign out_is_branch  = head.is_branch;
  assign out_is_jump    = head.is_jump;
`ifdef ILLEGAL_INSTR_FLAG_EN
  assign out_illegal    = head.illegal;
`endif
  assign occupancy      = count_q;

endmodule
